// File: rtl/bick_gen.sv
// Audio bit clock (BICK) and frame clock (LRCK) generator.
// BICK is an integer divide of clk_300m; LRCK toggles only on BICK falling
// edges. Divide and frame length are latched at start and at each frame
// boundary, and stopping only happens on a frame boundary.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | outputs low, counters cleared, waiting for en
// RUN   | dividing clk_300m into BICK, counting bits, driving LRCK
module bick_gen #(
  parameter int DIV_W   = 8,
  parameter int FRAME_W = 7
) (
  input  logic               clk_300m,
  input  logic               rst,
  input  logic               en,
  input  logic [DIV_W-1:0]   half_period,
  input  logic [FRAME_W-1:0] frame_bits,
  output logic               bick_out,
  output logic               lrck_out,
  output logic               bick_rise_pulse,
  output logic               bick_fall_pulse,
  output logic               frame_start,
  output logic               running
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state, state_n;
  logic [DIV_W-1:0]   div_cnt, div_n;
  logic [FRAME_W-1:0] bit_cnt, bit_n;
  logic [DIV_W-1:0]   hp_q, hp_n;
  logic [FRAME_W-1:0] fb_q, fb_n;
  logic               bick_n, lrck_n, rise_n, fall_n, fs_n, run_n;

  logic [DIV_W-1:0]   hp_eff;
  logic [FRAME_W-1:0] fb_clr, fb_eff, half_q;

  // Sanitised settings: half period of 0 acts as 1, frame length is even and at least 2
  always_comb begin
    hp_eff = (half_period == '0) ? DIV_W'(1) : half_period;
    fb_clr = {frame_bits[FRAME_W-1:1], 1'b0};
    fb_eff = (fb_clr < FRAME_W'(2)) ? FRAME_W'(2) : fb_clr;
    half_q = fb_q >> 1;
  end

  // Register every output and counter so the generated clocks are glitch-free
  always_ff @(posedge clk_300m) begin
    if (rst) begin
      state           <= IDLE;
      div_cnt         <= '0;
      bit_cnt         <= '0;
      hp_q            <= '0;
      fb_q            <= '0;
      bick_out        <= 1'b0;
      lrck_out        <= 1'b0;
      bick_rise_pulse <= 1'b0;
      bick_fall_pulse <= 1'b0;
      frame_start     <= 1'b0;
      running         <= 1'b0;
    end else begin
      state           <= state_n;
      div_cnt         <= div_n;
      bit_cnt         <= bit_n;
      hp_q            <= hp_n;
      fb_q            <= fb_n;
      bick_out        <= bick_n;
      lrck_out        <= lrck_n;
      bick_rise_pulse <= rise_n;
      bick_fall_pulse <= fall_n;
      frame_start     <= fs_n;
      running         <= run_n;
    end
  end

  // Next-state, divider, bit counter and strobe generation
  always_comb begin
    state_n = state;
    div_n   = div_cnt;
    bit_n   = bit_cnt;
    hp_n    = hp_q;
    fb_n    = fb_q;
    bick_n  = bick_out;
    lrck_n  = lrck_out;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    fs_n    = 1'b0;
    run_n   = running;

    case (state)
      IDLE: begin
        div_n  = '0;
        bit_n  = '0;
        bick_n = 1'b0;
        lrck_n = 1'b0;
        run_n  = 1'b0;
        if (en) begin
          state_n = RUN;
          hp_n    = hp_eff;
          fb_n    = fb_eff;
          run_n   = 1'b1;
        end
      end

      RUN: begin
        if (div_cnt == hp_q - DIV_W'(1)) begin
          div_n = '0;
          if (!bick_out) begin
            bick_n = 1'b1;
            rise_n = 1'b1;
          end else begin
            bick_n = 1'b0;
            fall_n = 1'b1;
            if (bit_cnt == fb_q - FRAME_W'(1)) begin
              // Frame boundary: the only point where settings and en are honoured
              bit_n  = '0;
              lrck_n = 1'b0;
              hp_n   = hp_eff;
              fb_n   = fb_eff;
              if (en) begin
                fs_n = 1'b1;
              end else begin
                state_n = IDLE;
                run_n   = 1'b0;
              end
            end else begin
              bit_n = bit_cnt + FRAME_W'(1);
              if (bit_cnt == half_q - FRAME_W'(1))
                lrck_n = 1'b1;
            end
          end
        end else begin
          div_n = div_cnt + DIV_W'(1);
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bick_gen.sv
// Self-checking bench for bick_gen. Expected outputs come from a closed-form
// waveform model (phase = k/hp, bit = k/(2*hp)) pushed into a scoreboard queue
// and popped one entry per clock as the DUT produces its outputs.
module tb_bick_gen;

  localparam int DIV_W   = 8;
  localparam int FRAME_W = 7;

  logic               clk_300m = 1'b0;
  logic               rst;
  logic               en;
  logic [DIV_W-1:0]   half_period;
  logic [FRAME_W-1:0] frame_bits;
  logic               bick_out, lrck_out, bick_rise_pulse, bick_fall_pulse;
  logic               frame_start, running;

  int tests_run    = 0;
  int tests_failed = 0;

  // {running, bick, lrck, rise, fall, frame_start}
  logic [5:0] exp_q[$];
  int         cnt_q[$];

  bick_gen #(.DIV_W(DIV_W), .FRAME_W(FRAME_W)) dut (
    .clk_300m        (clk_300m),
    .rst             (rst),
    .en              (en),
    .half_period     (half_period),
    .frame_bits      (frame_bits),
    .bick_out        (bick_out),
    .lrck_out        (lrck_out),
    .bick_rise_pulse (bick_rise_pulse),
    .bick_fall_pulse (bick_fall_pulse),
    .frame_start     (frame_start),
    .running         (running)
  );

  always #5 clk_300m = ~clk_300m;

  function automatic logic [5:0] obs();
    return {running, bick_out, lrck_out, bick_rise_pulse, bick_fall_pulse, frame_start};
  endfunction

  // Expected outputs k cycles after RUN entry (or after a frame boundary when first=0)
  function automatic logic [5:0] exp_at(int k, int hp, int fb, bit first);
    int  ph, bi;
    bit  b, l, e, r, f, s;
    ph = k / hp;
    bi = k / (2 * hp);
    b  = (ph % 2) == 1;
    l  = (bi % fb) >= (fb / 2);
    e  = (k % hp) == 0;
    r  = e && b;
    f  = e && !b && (k > 0 || !first);
    s  = f && ((bi % fb) == 0);
    return {1'b1, b, l, r, f, s};
  endfunction

  task automatic tick();
    @(posedge clk_300m);
    #1;
  endtask

  // Run n cycles of a steady-settings segment, with optional mid-segment input changes
  task automatic run_seg(input string name, input int hp, input int fb, input int n,
                         input bit first, input int hp_chg_at, input int hp_new,
                         input int en_off_at, input int en_on_at);
    logic [5:0] e, a;
    for (int k = 0; k < n; k++) exp_q.push_back(exp_at(k, hp, fb, first));
    for (int i = 0; i < n; i++) begin
      if (i == hp_chg_at) half_period = DIV_W'(hp_new);
      if (i == en_off_at) en = 1'b0;
      if (i == en_on_at)  en = 1'b1;
      e = exp_q.pop_front();
      a = obs();
      tests_run++;
      if (a !== e) begin
        tests_failed++;
        $display("FAIL %s k=%0d got=%b expected=%b", name, i, a, e);
      end
      tick();
    end
  endtask

  task automatic start(input int hp_in, input int fb_in);
    rst = 1'b1; en = 1'b0;
    tick();
    rst = 1'b0;
    half_period = DIV_W'(hp_in);
    frame_bits  = FRAME_W'(fb_in);
    en = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [5:0] e, a;
    rst = 1'b1; en = 1'b0; half_period = 8'd2; frame_bits = 7'd4;
    tick(); tick();
    exp_q.push_back(6'b0);
    rst = 1'b0;
    tick();
    exp_q.push_back(6'b0);
    exp_q.push_back(6'b0);
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      a = obs();
      tests_run++;
      if (a !== e) begin
        tests_failed++;
        $display("FAIL reset_idle i=%0d got=%b expected=%b", i, a, e);
      end
      if (i < 2) tick();
    end
  endtask

  task automatic test_basic();
    start(2, 4);
    run_seg("basic_hp2_fb4", 2, 4, 48, 1'b1, -1, 0, -1, -1);
  endtask

  task automatic test_min_settings();
    start(0, 3);
    run_seg("hp0_fb3", 1, 2, 20, 1'b1, -1, 0, -1, -1);
  endtask

  task automatic test_mid_change();
    start(2, 8);
    run_seg("hp_change_old", 2, 8, 32, 1'b1, 6, 4, -1, -1);
    run_seg("hp_change_new", 4, 8, 64, 1'b0, -1, 0, -1, -1);
  endtask

  task automatic test_stop();
    logic [5:0] e, a;
    start(3, 64);
    run_seg("stop_frame", 3, 64, 384, 1'b1, -1, 0, 60, -1);
    exp_q.push_back(6'b000010);
    for (int i = 0; i < 12; i++) exp_q.push_back(6'b0);
    for (int i = 0; i < 13; i++) begin
      e = exp_q.pop_front();
      a = obs();
      tests_run++;
      if (a !== e) begin
        tests_failed++;
        $display("FAIL stop_idle i=%0d got=%b expected=%b", i, a, e);
      end
      tick();
    end
    en = 1'b1;
    tick();
    run_seg("rearm_frame", 3, 64, 384, 1'b1, -1, 0, 60, 240);
    run_seg("rearm_next", 3, 64, 12, 1'b0, -1, 0, -1, -1);
  endtask

  task automatic test_reset_mid();
    logic [5:0] e, a;
    start(2, 4);
    run_seg("pre_rst", 2, 4, 3, 1'b1, -1, 0, -1, -1);
    exp_q.push_back(6'b0);
    exp_q.push_back(6'b0);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      e = exp_q.pop_front();
      a = obs();
      tests_run++;
      if (a !== e) begin
        tests_failed++;
        $display("FAIL rst_mid i=%0d got=%b expected=%b", i, a, e);
      end
    end
    rst = 1'b0;
    tick();
    run_seg("post_rst", 2, 4, 20, 1'b1, -1, 0, -1, -1);
  endtask

  task automatic test_back_to_back_fast();
    int rises, falls, fss, both, ex, ac;
    rises = 0; falls = 0; fss = 0; both = 0;
    start(1, 2);
    cnt_q.push_back(500);
    cnt_q.push_back(500);
    cnt_q.push_back(250);
    cnt_q.push_back(0);
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (bick_rise_pulse) rises++;
      if (bick_fall_pulse) falls++;
      if (frame_start) fss++;
      if (bick_rise_pulse && bick_fall_pulse) both++;
    end
    for (int i = 0; i < 4; i++) begin
      ex = cnt_q.pop_front();
      case (i)
        0: ac = rises;
        1: ac = falls;
        2: ac = fss;
        default: ac = both;
      endcase
      tests_run++;
      if (ac !== ex) begin
        tests_failed++;
        $display("FAIL fast_count idx=%0d got=%0d expected=%0d", i, ac, ex);
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; half_period = '0; frame_bits = '0;
    test_reset();
    test_basic();
    test_min_settings();
    test_mid_change();
    test_stop();
    test_reset_mid();
    test_back_to_back_fast();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
